// File: rtl/nios_pio_pkg.sv
// Shared register map and field widths for the nios_system output PIO.
// Imported by nios_system_pio_out and nios_pio_pulse_timer.
package nios_pio_pkg;

    localparam int PULSE_CNT_W     = 16;
    localparam int STATUS_BUSY_BIT = 0;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
    localparam logic [2:0] ADDR_PULSE     = 3'd6;

    // Expands the four byteenable bits into a 32-bit per-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/nios_pio_pulse_timer.sv
// 16-bit load/decrement pulse counter; a load always beats the decrement,
// which gives retrigger semantics. busy_next lets the top register out_port.
module nios_pio_pulse_timer
    import nios_pio_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [PULSE_CNT_W-1:0] len,
    output logic                   busy,
    output logic                   busy_next
);

    logic [PULSE_CNT_W-1:0] cnt;
    logic [PULSE_CNT_W-1:0] cnt_next;

    // NOTE: combinational blocks assign a default first so no path leaves
    // cnt_next unassigned; otherwise a latch would be inferred.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = len;
        end else if (cnt != '0) begin
            cnt_next = cnt - PULSE_CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign busy      = (cnt != '0);
    assign busy_next = (cnt_next != '0);

endmodule

// File: rtl/nios_system_pio_out.sv
// Avalon-MM output PIO with set/clear writes and a self-timed pulse register.
// Optional byte-lane write masking: define PIO_OUT_BYTEENABLE_EN.
module nios_system_pio_out
    import nios_pio_pkg::*;
#(
    parameter int          DATA_WIDTH      = 32,
    parameter logic [31:0] RESET_VALUE     = 32'h0,
    parameter logic [15:0] PULSE_LEN_RESET = 16'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0]  data_reg;
    logic [DATA_WIDTH-1:0]  data_next;
    logic [DATA_WIDTH-1:0]  pulse_mask;
    logic [DATA_WIDTH-1:0]  mask_next;
    logic [DATA_WIDTH-1:0]  out_next;
    logic [PULSE_CNT_W-1:0] pulse_len;
    logic [PULSE_CNT_W-1:0] len_next;
    logic [31:0]            rd_next;
    logic [31:0]            lanes;
    logic [DATA_WIDTH-1:0]  wd;
    logic [DATA_WIDTH-1:0]  be;
    logic                   wr_en;
    logic                   pulse_load;
    logic                   busy;
    logic                   busy_next;

`ifdef PIO_OUT_BYTEENABLE_EN
    assign lanes = lane_mask(byteenable);
`else
    assign lanes = '1;
`endif

    assign wr_en = chipselect & ~write_n;
    assign wd    = writedata[DATA_WIDTH-1:0];
    assign be    = lanes[DATA_WIDTH-1:0];

    // Bits above DATA_WIDTH and, in the full-word build, byteenable are dropped.
    logic unused_bits;
    assign unused_bits = ^{byteenable, writedata, lanes};

    always_comb begin
        data_next  = data_reg;
        len_next   = pulse_len;
        pulse_load = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:      data_next = (data_reg & ~be) | (wd & be);
                ADDR_PULSE_LEN: len_next  = (pulse_len & ~lanes[15:0])
                                          | (writedata[15:0] & lanes[15:0]);
                ADDR_OUTSET:    data_next = data_reg | (wd & be);
                ADDR_OUTCLEAR:  data_next = data_reg & ~(wd & be);
                ADDR_PULSE:     pulse_load = 1'b1;
                default:        ;
            endcase
        end
    end

    nios_pio_pulse_timer u_pulse_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (pulse_load),
        .len       (pulse_len),
        .busy      (busy),
        .busy_next (busy_next)
    );

    // A new pulse write replaces the mask; a natural expiry clears it.
    always_comb begin
        mask_next = pulse_mask;
        if (pulse_load) begin
            mask_next = (pulse_mask & ~be) | (wd & be);
        end else if (busy && !busy_next) begin
            mask_next = '0;
        end
        out_next = data_next ^ (busy_next ? mask_next : '0);
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:      rd_next[DATA_WIDTH-1:0]  = data_reg;
            ADDR_PULSE_LEN: rd_next[PULSE_CNT_W-1:0] = pulse_len;
            ADDR_STATUS:    rd_next[STATUS_BUSY_BIT] = busy;
            default:        ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg   <= RST_DATA;
            pulse_mask <= '0;
            pulse_len  <= PULSE_LEN_RESET;
            out_port   <= RST_DATA;
            readdata   <= '0;
        end else begin
            data_reg   <= data_next;
            pulse_mask <= mask_next;
            pulse_len  <= len_next;
            out_port   <= out_next;
            readdata   <= rd_next;
        end
    end

endmodule
